crc_frame_checker: RTL

Parametrised successor to the fixed CRC-8/CRC-16 SPI-side accumulator. It runs one configurable-width, configurable-polynomial CRC over a framed MOSI bit stream, MSB-first. The engine is clocked by spi_clk. Each frame is FRAME_BYTES payload bytes followed by a CRC_WIDTH/8-byte trailer. The block captures the trailer, compares it against the computed CRC, and flags pass/fail per frame. It sits between the SPI slave front end and the cart command decoder.

---
 rtl/crc_frame_checker.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/crc_frame_checker.sv
// ---------------------------------------------------------------------------
// crc_frame_checker
//
// Runs one configurable CRC (normal form, MSB-first) over a framed serial
// stream. Each frame is FRAME_BYTES payload bytes followed by a
// CRC_WIDTH/8-byte trailer. The trailer is captured and compared against the
// computed payload CRC, and a pass/fail flag is raised per frame.
//
// Optional feature: define CRC_FRAME_ERR_CNT_EN to add a saturating 8-bit
// counter of failed frames on output err_count.
//
// Ports:
//   spi_clk     in   sole clock, rising edge
//   reset       in   synchronous active-high reset (wins over en)
//   en          in   bit enable; mosi is sampled only when en=1
//   mosi        in   serial data, MSB first
//   crc_result  out  payload CRC ^ XOR_OUT, latched at end of payload
//   byte_strobe out  one-cycle pulse after the 8th bit of any byte
//   frame_done  out  one-cycle pulse after the last trailer bit
//   crc_ok      out  trailer == crc_result, held until the next frame_done
//   busy        out  high from the first bit of a frame until frame_done
//   err_count   out  failed-frame count, saturating (CRC_FRAME_ERR_CNT_EN)
// ---------------------------------------------------------------------------
module crc_frame_checker #(
    parameter int                   CRC_WIDTH   = 16,
    parameter logic [CRC_WIDTH-1:0] POLY        = 16'h1021,
    parameter logic [CRC_WIDTH-1:0] INIT        = 16'h0000,
    parameter logic [CRC_WIDTH-1:0] XOR_OUT     = 16'h0000,
    parameter int                   FRAME_BYTES = 4
) (
    input  logic                 spi_clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 mosi,
    output logic [CRC_WIDTH-1:0] crc_result,
    output logic                 byte_strobe,
    output logic                 frame_done,
    output logic                 crc_ok,
    output logic                 busy
`ifdef CRC_FRAME_ERR_CNT_EN
    ,
    output logic [7:0]           err_count
`endif
);

    typedef enum logic {
        PAYLOAD = 1'b0,
        TRAILER = 1'b1
    } state_e;

    localparam logic [7:0] LAST_PAYLOAD = 8'(FRAME_BYTES - 1);
    localparam logic [7:0] LAST_TRAILER = 8'(CRC_WIDTH / 8 - 1);

    state_e               state_q, state_d;
    logic [CRC_WIDTH-1:0] crc_q, crc_d;
    logic [CRC_WIDTH-1:0] expect_q, expect_d;
    logic [CRC_WIDTH-1:0] crc_result_q, crc_result_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [7:0]           byte_cnt_q, byte_cnt_d;
    logic                 byte_strobe_q, byte_strobe_d;
    logic                 frame_done_q, frame_done_d;
    logic                 crc_ok_q, crc_ok_d;
    logic                 busy_q, busy_d;
`ifdef CRC_FRAME_ERR_CNT_EN
    logic [7:0]           err_cnt_q, err_cnt_d;
`endif

    logic [CRC_WIDTH-1:0] crc_step;
    logic [CRC_WIDTH-1:0] expect_step;
    logic                 last_bit;

    // One LFSR step of the CRC and one shift of the trailer capture register.
    assign crc_step    = {crc_q[CRC_WIDTH-2:0], 1'b0}
                       ^ (POLY & {CRC_WIDTH{crc_q[CRC_WIDTH-1] ^ mosi}});
    assign expect_step = {expect_q[CRC_WIDTH-2:0], mosi};
    assign last_bit    = (bit_cnt_q == 3'd7);

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        crc_d         = crc_q;
        expect_d      = expect_q;
        crc_result_d  = crc_result_q;
        bit_cnt_d     = bit_cnt_q;
        byte_cnt_d    = byte_cnt_q;
        byte_strobe_d = 1'b0;
        frame_done_d  = 1'b0;
        crc_ok_d      = crc_ok_q;
        busy_d        = busy_q;
`ifdef CRC_FRAME_ERR_CNT_EN
        err_cnt_d     = err_cnt_q;
`endif

        if (en) begin
            bit_cnt_d     = bit_cnt_q + 3'd1;
            byte_strobe_d = last_bit;
            unique case (state_q)
                PAYLOAD: begin
                    crc_d  = crc_step;
                    busy_d = 1'b1;
                    if (last_bit) begin
                        if (byte_cnt_q == LAST_PAYLOAD) begin
                            // Latch from the next-state value so the last bit
                            // is included without a cycle of delay.
                            crc_result_d = crc_step ^ XOR_OUT;
                            byte_cnt_d   = 8'd0;
                            state_d      = TRAILER;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 8'd1;
                        end
                    end
                end
                TRAILER: begin
                    expect_d = expect_step;
                    if (last_bit) begin
                        if (byte_cnt_q == LAST_TRAILER) begin
                            frame_done_d = 1'b1;
                            crc_ok_d     = (expect_step == crc_result_q);
                            busy_d       = 1'b0;
                            crc_d        = INIT;
                            byte_cnt_d   = 8'd0;
                            state_d      = PAYLOAD;
`ifdef CRC_FRAME_ERR_CNT_EN
                            if ((expect_step != crc_result_q) && (err_cnt_q != 8'hFF))
                                err_cnt_d = err_cnt_q + 8'd1;
`endif
                        end else begin
                            byte_cnt_d = byte_cnt_q + 8'd1;
                        end
                    end
                end
                default: state_d = PAYLOAD;
            endcase
        end
    end

    always_ff @(posedge spi_clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values, independent of statement order.
        if (reset) begin
            state_q       <= PAYLOAD;
            crc_q         <= INIT;
            expect_q      <= '0;
            crc_result_q  <= '0;
            bit_cnt_q     <= 3'd0;
            byte_cnt_q    <= 8'd0;
            byte_strobe_q <= 1'b0;
            frame_done_q  <= 1'b0;
            crc_ok_q      <= 1'b0;
            busy_q        <= 1'b0;
`ifdef CRC_FRAME_ERR_CNT_EN
            err_cnt_q     <= 8'd0;
`endif
        end else begin
            state_q       <= state_d;
            crc_q         <= crc_d;
            expect_q      <= expect_d;
            crc_result_q  <= crc_result_d;
            bit_cnt_q     <= bit_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            byte_strobe_q <= byte_strobe_d;
            frame_done_q  <= frame_done_d;
            crc_ok_q      <= crc_ok_d;
            busy_q        <= busy_d;
`ifdef CRC_FRAME_ERR_CNT_EN
            err_cnt_q     <= err_cnt_d;
`endif
        end
    end

    assign crc_result  = crc_result_q;
    assign byte_strobe = byte_strobe_q;
    assign frame_done  = frame_done_q;
    assign crc_ok      = crc_ok_q;
    assign busy        = busy_q;
`ifdef CRC_FRAME_ERR_CNT_EN
    assign err_count   = err_cnt_q;
`endif

endmodule
